// File: rtl/pulse_shaper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_shaper_pkg
// Description : Polarity constants shared by the pulse generator and the
//               edge-detecting consumer, plus a small sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_shaper_pkg;

    localparam bit EDGE_RISING  = 1'b1;
    localparam bit EDGE_FALLING = 1'b0;

    function automatic int unsigned max_uint(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_shaper.sv
`default_nettype none
// ============================================================================
// Module      : pulse_shaper
// Description : Turns single-cycle requests into fixed-width level pulses with
//               a guaranteed idle gap; overlapping requests are queued.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_shaper
    import pulse_shaper_pkg::*;
#(
    parameter bit          EDGE         = EDGE_RISING,
    parameter int unsigned WIDTH_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned PENDING_MAX  = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 pulse_req,
    output logic                                 signal,
    output logic                                 busy,
    output logic [$clog2(PENDING_MAX+1)-1:0]     pending,
    output logic                                 overflow
);

    localparam int unsigned CNT_MAX = max_uint(WIDTH_CYCLES, GAP_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned PEND_W  = $clog2(PENDING_MAX + 1);

    localparam logic [CNT_W-1:0]  C_WIDTH_LAST = CNT_W'(WIDTH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  C_GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] C_PEND_MAX   = PEND_W'(PENDING_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_e;

    state_e              state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [PEND_W-1:0]   pending_q, pending_d;
    logic                signal_q,  signal_d;

    logic                w_enqueue;
    logic                w_dequeue;
    logic                w_overflow;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            signal_q  <= ~EDGE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            signal_q  <= signal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        signal_d  = signal_q;
        w_enqueue = 1'b0;
        w_dequeue = 1'b0;

        case (state_q)
            IDLE: begin
                if (pulse_req) begin
                    state_d  = ACTIVE;
                    cnt_d    = '0;
                    signal_d = EDGE;
                end
            end

            ACTIVE: begin
                w_enqueue = pulse_req;
                if (cnt_q == C_WIDTH_LAST) begin
                    state_d  = GAP;
                    cnt_d    = '0;
                    signal_d = ~EDGE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            GAP: begin
                if (cnt_q == C_GAP_LAST) begin
                    cnt_d = '0;
                    if (pending_q != '0) begin
                        // Queued work goes first; a fresh request joins the queue.
                        state_d   = ACTIVE;
                        signal_d  = EDGE;
                        w_dequeue = 1'b1;
                        w_enqueue = pulse_req;
                    end else if (pulse_req) begin
                        state_d  = ACTIVE;
                        signal_d = EDGE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    w_enqueue = pulse_req;
                end
            end

            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                signal_d = ~EDGE;
            end
        endcase
    end

    // A dequeue paired with an enqueue nets to zero and can never overflow.
    always_comb begin
        pending_d  = pending_q;
        w_overflow = 1'b0;
        if (w_enqueue && !w_dequeue) begin
            if (pending_q == C_PEND_MAX) begin
                w_overflow = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (w_dequeue && !w_enqueue) begin
            pending_d = pending_q - PEND_W'(1);
        end
    end

    assign signal   = signal_q;
    assign pending  = pending_q;
    assign busy     = (state_q != IDLE) || (pending_q != '0);
    assign overflow = w_overflow;

    a_pending_bound : assert property (@(posedge clk) disable iff (reset)
        pending_q <= C_PEND_MAX);

    a_idle_empty : assert property (@(posedge clk) disable iff (reset)
        (state_q == IDLE) |-> (pending_q == '0));

endmodule
`default_nettype wire

// File: tb/tb_pulse_shaper.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_shaper
// Description : Directed bench for pulse_shaper (W=3, G=2, PENDING_MAX=2),
//               with an EDGE=0 instance feeding a falling-edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_shaper;
    import pulse_shaper_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a;
    logic       req_b;
    logic       sig_a, busy_a, ovf_a;
    logic       sig_b, busy_b, ovf_b;
    logic [1:0] pend_a, pend_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pulse_shaper #(
        .EDGE(EDGE_RISING), .WIDTH_CYCLES(3), .GAP_CYCLES(2), .PENDING_MAX(2)
    ) u_dut_a (
        .clk(clk), .reset(reset), .pulse_req(req_a), .signal(sig_a),
        .busy(busy_a), .pending(pend_a), .overflow(ovf_a)
    );

    pulse_shaper #(
        .EDGE(EDGE_FALLING), .WIDTH_CYCLES(3), .GAP_CYCLES(2), .PENDING_MAX(2)
    ) u_dut_b (
        .clk(clk), .reset(reset), .pulse_req(req_b), .signal(sig_b),
        .busy(busy_b), .pending(pend_b), .overflow(ovf_b)
    );

    // Consumer side: falling-edge detector on the EDGE=0 output.
    logic sig_b_q = 1'b1;
    logic fall_b;
    always @(posedge clk) sig_b_q <= sig_b;
    assign fall_b = sig_b_q & ~sig_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    // Drive one cycle's inputs at the falling edge, then let comb outputs settle.
    task automatic step(input logic rst_v, input logic ra, input logic rb);
        @(negedge clk);
        reset = rst_v;
        req_a = ra;
        req_b = rb;
        #1;
    endtask

    initial begin
        int rises;
        int falls;
        int low_run;
        int low_total;
        logic prev;
        logic [1:0] exp_p;

        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (3) @(posedge clk);

        // Reset state
        step(1'b0, 1'b0, 1'b0);
        check("rst sig_a", 32'(sig_a), 32'd0);
        check("rst busy_a", 32'(busy_a), 32'd0);
        check("rst pend_a", 32'(pend_a), 32'd0);
        check("rst ovf_a", 32'(ovf_a), 32'd0);
        check("rst sig_b", 32'(sig_b), 32'd1);

        // 1: single request
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            step(1'b0, c == 10, 1'b0);
            check($sformatf("t1 sig c%0d", c), 32'(sig_a), 32'(in_rng(c, 11, 13)));
            check($sformatf("t1 busy c%0d", c), 32'(busy_a), 32'(in_rng(c, 11, 15)));
            check($sformatf("t1 pend c%0d", c), 32'(pend_a), 32'd0);
        end

        // 2: burst of three
        do_reset();
        for (int c = 0; c <= 28; c++) begin
            step(1'b0, in_rng(c, 10, 12), 1'b0);
            exp_p = (c == 12) ? 2'd1 : in_rng(c, 13, 15) ? 2'd2 : in_rng(c, 16, 20) ? 2'd1 : 2'd0;
            check($sformatf("t2 sig c%0d", c), 32'(sig_a),
                  32'(in_rng(c, 11, 13) || in_rng(c, 16, 18) || in_rng(c, 21, 23)));
            check($sformatf("t2 pend c%0d", c), 32'(pend_a), 32'(exp_p));
            check($sformatf("t2 busy c%0d", c), 32'(busy_a), 32'(in_rng(c, 11, 25)));
            check($sformatf("t2 ovf c%0d", c), 32'(ovf_a), 32'd0);
        end

        // 3: overflow on the fourth back-to-back request
        do_reset();
        rises = 0;
        prev  = 1'b0;
        for (int c = 0; c <= 30; c++) begin
            step(1'b0, in_rng(c, 10, 13), 1'b0);
            exp_p = (c == 12) ? 2'd1 : in_rng(c, 13, 15) ? 2'd2 : in_rng(c, 16, 20) ? 2'd1 : 2'd0;
            check($sformatf("t3 ovf c%0d", c), 32'(ovf_a), 32'(c == 13));
            check($sformatf("t3 pend c%0d", c), 32'(pend_a), 32'(exp_p));
            if (sig_a && !prev) rises++;
            prev = sig_a;
        end
        check("t3 pulses", 32'(rises), 32'd3);

        // 4: request in the last GAP cycle chains with no IDLE
        do_reset();
        for (int c = 0; c <= 22; c++) begin
            step(1'b0, (c == 10) || (c == 15), 1'b0);
            check($sformatf("t4 sig c%0d", c), 32'(sig_a),
                  32'(in_rng(c, 11, 13) || in_rng(c, 16, 18)));
            check($sformatf("t4 busy c%0d", c), 32'(busy_a), 32'(in_rng(c, 11, 20)));
            check($sformatf("t4 pend c%0d", c), 32'(pend_a), 32'd0);
        end

        // 5: reset mid-pulse abandons the pulse and the queue
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            step(c == 12, (c == 10) || (c == 11) || (c == 14), 1'b0);
            check($sformatf("t5 sig c%0d", c), 32'(sig_a),
                  32'(in_rng(c, 11, 12) || in_rng(c, 15, 17)));
            check($sformatf("t5 busy c%0d", c), 32'(busy_a),
                  32'(in_rng(c, 11, 12) || in_rng(c, 15, 19)));
            check($sformatf("t5 pend c%0d", c), 32'(pend_a), 32'(c == 12));
        end

        // 6: falling-polarity loopback through the edge detector
        do_reset();
        falls     = 0;
        low_run   = 0;
        low_total = 0;
        for (int c = 0; c <= 40; c++) begin
            step(1'b0, 1'b0, (c == 3) || (c == 5) || (c == 12) || (c == 25) || (c == 27));
            if (c == 0) check("t6 idle high", 32'(sig_b), 32'd1);
            check($sformatf("t6 ovf c%0d", c), 32'(ovf_b), 32'd0);
            if (fall_b) falls++;
            if (!sig_b) begin
                low_run++;
                low_total++;
            end else if (low_run != 0) begin
                check($sformatf("t6 low run c%0d", c), 32'(low_run), 32'd3);
                low_run = 0;
            end
        end
        check("t6 falls", 32'(falls), 32'd5);
        check("t6 low total", 32'(low_total), 32'd15);
        check("t6 end idle", 32'(sig_b), 32'd1);
        check("t6 end busy", 32'(busy_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_shaper.md
Name: pulse_shaper

Overview:
Generator side of edge signalling. It turns single-cycle request pulses into clean, fixed-width level pulses with a guaranteed minimum idle gap between them. A downstream edge-detecting consumer, possibly slower or filtered, therefore sees exactly one edge per request. Requests that arrive while a pulse is in progress are queued in a saturating pending counter. Typical uses are frame/line strobes toward the video and audio paths.

Parameters:
EDGE, 1, active polarity: 1 = output idles low and pulses high; 0 = output idles high and pulses low
WIDTH_CYCLES, 4, cycles the output is held at the active level per pulse; must be >= 1
GAP_CYCLES, 2, minimum cycles at the idle level after each pulse before the next may start; must be >= 1
PENDING_MAX, 3, maximum number of queued requests; must be >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
pulse_req  input  1  single-cycle request; each cycle high counts as one request
signal  output  1  shaped pulse output, registered
busy  output  1  high when the state is not IDLE or pending != 0; combinational from registers
pending  output  $clog2(PENDING_MAX+1)  number of queued requests, registered
overflow  output  1  combinational; high in the same cycle a request is dropped

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values:
  - state = IDLE
  - signal = ~EDGE (idle level)
  - pending = 0
  - internal counter = 0
  - busy = 0
- Reset mid-pulse: at the reset edge, signal returns to idle, the queue is cleared, and the in-flight pulse is abandoned with no gap enforced.
- States: IDLE, ACTIVE, GAP. The counter is sized $clog2(max(WIDTH_CYCLES, GAP_CYCLES)+1).
- IDLE, pulse_req=1 in cycle t:
  - signal is active in cycles t+1 .. t+WIDTH_CYCLES (latency 1).
  - signal is idle in cycles t+WIDTH_CYCLES+1 .. t+WIDTH_CYCLES+GAP_CYCLES.
- ACTIVE: counts WIDTH_CYCLES cycles, then goes to GAP; signal goes idle on that transition.
- GAP, last cycle:
  - pending > 0: go to ACTIVE and decrement pending.
  - pending == 0 and pulse_req: go to ACTIVE, consuming the request directly; pending stays 0.
  - otherwise: go to IDLE.
- Queueing: pulse_req while in ACTIVE or GAP, and not consumed as above, increments pending.
- Simultaneous dequeue and request (last GAP cycle, pending > 0, pulse_req=1): pending is unchanged.
- Saturation: a request that would push pending above PENDING_MAX is dropped. overflow=1 in that cycle, pending stays at PENDING_MAX. Nothing else changes.
- Continuous requests: back-to-back pulses have period exactly WIDTH_CYCLES+GAP_CYCLES. signal never shows an active run shorter or longer than WIDTH_CYCLES. signal never shows an idle run between pulses shorter than GAP_CYCLES.
- Glitch-free: signal is driven only from a flop.
- Arithmetic: all counters are unsigned. The pending increment is guarded by saturation and the decrement by pending != 0, so neither can wrap.

Decomposition:
- Shared constants package/header: EDGE_RISING=1 and EDGE_FALLING=0, shared with the edge detector so both ends agree on polarity.
- State encoding: localparams local to this module.
- No sub-module. The pending counter and phase counter are simple enough to stay inline.

Test Plan:
(WIDTH_CYCLES=3, GAP_CYCLES=2, PENDING_MAX=2, EDGE=1 unless stated.)
1. Single request: pulse_req at cycle 10 -> signal high 11-13, low from 14; busy high 11-15, low at 16; pending=0 throughout.
2. Burst: pulse_req at cycles 10, 11, 12 -> pulses at 11-13, 16-18, 21-23; pending=1 at 12, 2 at 13, 1 at 16, 0 at 21.
3. Overflow: pulse_req at cycles 10-13 -> overflow=1 at cycle 13 only; pending stays 2; exactly 3 pulses are emitted.
4. Boundary: pulse_req at cycle 10 and at cycle 15 (last GAP cycle) -> second pulse at 16-18 with no IDLE cycle; pending stays 0.
5. Reset mid-pulse: pulse_req at 10 and 11, reset at cycle 12 -> signal low from 13, pending=0, busy=0; a new pulse_req at 14 gives a pulse at 15-17.
6. Polarity loopback: EDGE=0, 5 random-spaced requests (max 2 queued), output fed to an edge detector with EDGE=0 -> signal idles high, exactly 5 falling-edge pulses, each low run = 3 cycles.
